// File: rtl/mem_panel_ctrl.sv
// Front-panel memory controller: debounced address/write pushbuttons drive a
// 16-bit word memory, each write is read back and verified, and the address
// optionally auto-increments after each write.

// Per-button conditioning: 2-flop synchronizer, stability counter, and a
// one-cycle press pulse on the accepted rising edge.
module mem_panel_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count while the synchronized level disagrees with the accepted level;
  // flip the accepted level once it has disagreed long enough.
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;   // only the rising edge makes a pulse
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Conditioning state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;
endmodule

module mem_panel_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ADDR_MAX        = 24575,
  parameter bit          AUTO_INC        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] SW,
  input  logic        BTN_addr,
  input  logic        BTN_write,
  input  logic [15:0] mem_rdata,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] disp_value,
  output logic        addr_err,
  output logic        wr_err,
  output logic [15:0] write_count
);
  localparam int NUM_BTN = 2;
  localparam int BTN_ADDR_IDX  = 0;
  localparam int BTN_WRITE_IDX = 1;
  localparam logic [14:0] ADDR_LAST = 15'(ADDR_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_INC    = 2'd3
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {BTN_write, BTN_addr};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    mem_panel_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[g]),
      .press (press[g])
    );
  end

  state_t      state_q, state_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [15:0] disp_q, disp_d;
  logic        addr_err_q, addr_err_d;
  logic        wr_err_q, wr_err_d;
  logic [15:0] wcount_q, wcount_d;

  // Command FSM: presses are only honoured in IDLE, address press wins a tie.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_err_d  = addr_err_q;
    wr_err_d    = wr_err_q;
    wcount_d    = wcount_q;
    disp_d      = mem_rdata;
    case (state_q)
      S_IDLE: begin
        if (press[BTN_ADDR_IDX]) begin
          if (SW[14:0] <= ADDR_LAST) begin
            mem_addr_d = SW[14:0];
            addr_err_d = 1'b0;
            wr_err_d   = 1'b0;
          end else begin
            addr_err_d = 1'b1;
          end
        end else if (press[BTN_WRITE_IDX]) begin
          mem_wdata_d = SW;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        // memory read is combinational, so the written word is visible now
        if (mem_rdata != mem_wdata_q) wr_err_d = 1'b1;
        if (wcount_q != 16'hFFFF) wcount_d = wcount_q + 16'd1;
        state_d = AUTO_INC ? S_INC : S_IDLE;
      end
      S_INC: begin
        mem_addr_d = (mem_addr_q == ADDR_LAST) ? 15'd0 : mem_addr_q + 15'd1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      disp_q      <= '0;
      addr_err_q  <= 1'b0;
      wr_err_q    <= 1'b0;
      wcount_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_q      <= disp_d;
      addr_err_q  <= addr_err_d;
      wr_err_q    <= wr_err_d;
      wcount_q    <= wcount_d;
    end
  end

  assign mem_we      = (state_q == S_WRITE);
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_value  = disp_q;
  assign addr_err    = addr_err_q;
  assign wr_err      = wr_err_q;
  assign write_count = wcount_q;
endmodule

// File: tb/tb_mem_panel_ctrl.sv
// Directed bench for mem_panel_ctrl with a small word-memory model.
module tb_mem_panel_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] SW;
  logic        BTN_addr;
  logic        BTN_write;
  logic [15:0] mem_rdata;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] disp_value;
  logic        addr_err;
  logic        wr_err;
  logic [15:0] write_count;

  int errors = 0;
  int checks = 0;

  mem_panel_ctrl #(.DEBOUNCE_CYCLES(4), .ADDR_MAX(24575), .AUTO_INC(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .SW          (SW),
    .BTN_addr    (BTN_addr),
    .BTN_write   (BTN_write),
    .mem_rdata   (mem_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .disp_value  (disp_value),
    .addr_err    (addr_err),
    .wr_err      (wr_err),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read back as 0x1000 + address.
  logic [15:0] mem     [0:24575];
  bit          written [0:24575];
  logic        force_en = 1'b0;
  logic        force_v  = 1'b0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    force_v <= force_en & mem_we;   // zero the read during the cycle after the write
  end

  assign mem_rdata = force_v ? 16'h0000 :
                     (written[mem_addr] ? mem[mem_addr] : 16'h1000 + {1'b0, mem_addr});

  // Write-strobe monitor.
  int          we_cnt = 0;
  logic [14:0] we_addr = '0;
  logic [15:0] we_data = '0;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= mem_addr;
      we_data <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_addr(input logic [15:0] sw);
    SW = sw;
    BTN_addr = 1'b1;
    tick(10);
    BTN_addr = 1'b0;
    tick(12);
  endtask

  task automatic press_write(input logic [15:0] sw);
    SW = sw;
    BTN_write = 1'b1;
    tick(10);
    BTN_write = 1'b0;
    tick(12);
  endtask

  typedef struct {
    logic [15:0] sw;
    logic [14:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];
  int   base;
  bit   seen;

  initial begin
    vecs[0] = '{16'h03E8, 15'd1000,  1'b0};
    vecs[1] = '{16'h7000, 15'd1000,  1'b1};
    vecs[2] = '{16'h5FFF, 15'd24575, 1'b0};
    vecs[3] = '{16'h6000, 15'd24575, 1'b1};
    vecs[4] = '{16'h8005, 15'd5,     1'b0};
    vecs[5] = '{16'h0000, 15'd0,     1'b0};
    vecs[6] = '{16'h7FFF, 15'd0,     1'b1};
    vecs[7] = '{16'h0005, 15'd5,     1'b0};

    reset = 1'b1; SW = '0; BTN_addr = 1'b0; BTN_write = 1'b0;
    tick(3);
    check("rst_addr",   mem_addr,    15'd0);
    check("rst_wdata",  mem_wdata,   16'd0);
    check("rst_we",     mem_we,      1'b0);
    check("rst_disp",   disp_value,  16'd0);
    check("rst_aerr",   addr_err,    1'b0);
    check("rst_werr",   wr_err,      1'b0);
    check("rst_wcount", write_count, 16'd0);
    reset = 1'b0;
    tick(5);
    check("idle_no_we", we_cnt, 0);

    // Address latch and range check
    for (int i = 0; i < 8; i++) begin
      press_addr(vecs[i].sw);
      check($sformatf("addr_latch[%0d]", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("addr_err[%0d]", i),   addr_err, vecs[i].exp_err);
    end
    check("addr_no_we", we_cnt, 0);

    // Write, verify, auto-increment, display latency
    base = we_cnt;
    SW = 16'hA5A5;
    BTN_write = 1'b1;
    for (int c = 0; c < 20 && mem_addr != 15'd6; c++) @(negedge clk);
    check("inc_reached", mem_addr, 15'd6);
    check("disp_prev",   disp_value, 16'hA5A5);
    tick(1);
    check("disp_new",    disp_value, 16'h1006);
    BTN_write = 1'b0;
    tick(12);
    check("wr_we_cnt",  we_cnt - base, 1);
    check("wr_we_addr", we_addr, 15'd5);
    check("wr_we_data", we_data, 16'hA5A5);
    check("wr_err_ok",  wr_err, 1'b0);
    check("wr_count1",  write_count, 16'd1);
    check("wr_wdata",   mem_wdata, 16'hA5A5);

    // Wrap at top address with a forced readback mismatch
    press_addr(16'h5FFF);
    check("top_addr", mem_addr, 15'd24575);
    force_en = 1'b1;
    press_write(16'h1234);
    force_en = 1'b0;
    check("wrap_we_addr", we_addr, 15'd24575);
    check("wrap_we_data", we_data, 16'h1234);
    check("mismatch_err", wr_err, 1'b1);
    check("wrap_count",   write_count, 16'd2);
    check("wrap_addr",    mem_addr, 15'd0);
    press_addr(16'h0010);
    check("err_cleared",  wr_err, 1'b0);
    check("addr_16",      mem_addr, 15'd16);
    check("count_kept",   write_count, 16'd2);

    // Short bounces on the address button are rejected
    SW = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      BTN_addr = ~k[0];
      tick(2);
    end
    BTN_addr = 1'b0;
    tick(10);
    check("bounce_addr", mem_addr, 15'd16);

    // Bouncing write button then a solid press: one write, none on release
    base = we_cnt;
    SW = 16'hBEEF;
    for (int k = 0; k < 4; k++) begin
      BTN_write = ~k[0];
      tick(2);
    end
    BTN_write = 1'b1;
    tick(10);
    BTN_write = 1'b0;
    tick(12);
    check("db_we_cnt",  we_cnt - base, 1);
    check("db_we_data", we_data, 16'hBEEF);
    check("db_addr",    mem_addr, 15'd17);
    check("db_count",   write_count, 16'd3);

    // Simultaneous presses: address wins, write dropped
    base = we_cnt;
    SW = 16'h0020;
    BTN_addr = 1'b1; BTN_write = 1'b1;
    tick(10);
    BTN_addr = 1'b0; BTN_write = 1'b0;
    tick(12);
    check("sim_addr",  mem_addr, 15'd32);
    check("sim_no_we", we_cnt - base, 0);
    check("sim_wdata", mem_wdata, 16'hBEEF);
    check("sim_aerr",  addr_err, 1'b0);

    // Address press landing in VERIFY is dropped
    base = we_cnt;
    SW = 16'h0100;
    BTN_write = 1'b1;
    tick(2);
    BTN_addr = 1'b1;
    tick(10);
    BTN_write = 1'b0;
    tick(2);
    BTN_addr = 1'b0;
    tick(12);
    check("busy_addr",    mem_addr, 15'd33);
    check("busy_we_cnt",  we_cnt - base, 1);
    check("busy_we_addr", we_addr, 15'd32);
    check("busy_wdata",   mem_wdata, 16'h0100);
    check("busy_count",   write_count, 16'd4);
    check("busy_werr",    wr_err, 1'b0);

    // Reset during WRITE
    base = we_cnt;
    seen = 1'b0;
    SW = 16'h0777;
    BTN_write = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = mem_we;
    end
    check("rst_mid_seen_we", seen, 1'b1);
    reset = 1'b1;
    BTN_write = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(12);
    check("rst_mid_we_cnt", we_cnt - base, 1);
    check("rst_mid_count",  write_count, 16'd0);
    check("rst_mid_werr",   wr_err, 1'b0);
    check("rst_mid_addr",   mem_addr, 15'd0);
    check("rst_mid_wdata",  mem_wdata, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_panel_ctrl.md
Name: mem_panel_ctrl

Overview:
- Front-panel initiator that drives the 16-bit word memory (RAM16K + SCREEN, 24576 words) from board switches and pushbuttons.
- Debounces BTN_addr and BTN_write and converts each press into a one-cycle command.
- Issues address and write strobes to the memory, then reads back to verify each write. Optionally auto-increments the address.
- Sits between the board I/O pins and the memory's address/data/write port. Drives the LED display value.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synchronized button level must stay changed before it is accepted (10 ms at 100 MHz).
- ADDR_MAX, 24575: highest legal word address.
- AUTO_INC, 1: when 1, the address increments after each completed write.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SW  in  16  switches: address in [14:0], or write data in [15:0].
- BTN_addr  in  1  raw pushbutton (asynchronous, bouncing); latches the address.
- BTN_write  in  1  raw pushbutton (asynchronous, bouncing); writes SW to memory.
- mem_rdata  in  16  memory read data for mem_addr (combinational in memory).
- mem_addr  out  15  registered memory address.
- mem_wdata  out  16  registered write data.
- mem_we  out  1  write strobe, one cycle per write.
- disp_value  out  16  mem_rdata registered; 1-cycle latency.
- addr_err  out  1  last address press was out of range.
- wr_err  out  1  sticky readback mismatch.
- write_count  out  16  completed writes, saturating.

Behaviour:
- Reset (synchronous, active-high) clears state to IDLE and zeroes the following:
  - all outputs;
  - both synchronizer chains and both debounce counters;
  - both stable levels.
- Input conditioning, per button:
  - 2-flop synchronizer.
  - Counter increments each cycle while the synchronized level differs from the stable level; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the levels still differing, the stable level flips and the counter clears.
  - A press pulse is high for exactly one cycle, on the stable rising edge only. Release produces no pulse.
  - Any bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: IDLE, WRITE, VERIFY, INC.
  - IDLE, addr press:
    - If SW[14:0] <= ADDR_MAX: mem_addr <= SW[14:0]; addr_err <= 0; wr_err <= 0.
    - Else: addr_err <= 1; mem_addr unchanged.
    - Stays in IDLE.
  - IDLE, write press (no addr press in the same cycle): mem_wdata <= SW; go to WRITE.
  - WRITE: mem_we = 1 for this single cycle; go to VERIFY.
  - VERIFY: wait one cycle for mem_rdata to reflect the write, then compare.
    - Mismatch: wr_err <= 1.
    - Always: write_count increments, saturating at 16'hFFFF.
    - Next state is INC if AUTO_INC = 1, else IDLE.
  - INC: mem_addr <= (mem_addr == ADDR_MAX) ? 0 : mem_addr + 1; go to IDLE.
- Command priority and dropping:
  - Addr and write pulses in the same IDLE cycle: the addr press wins and the write press is dropped.
  - Press pulses arriving outside IDLE are dropped, not queued.
- mem_we is never high outside WRITE; mem_addr is stable while mem_we is high.
- mem_wdata holds its value until the next write press.
- Reset during WRITE/VERIFY/INC: return to IDLE next cycle. No further mem_we; write_count and wr_err are cleared.

Test Plan:
- DEBOUNCE_CYCLES = 4 for all scenarios.
- Reset: hold reset for 3 cycles, then release → all outputs 0, no mem_we.
- Address latch and range check:
  - SW = 16'h03E8, BTN_addr held 10 cycles → one pulse; mem_addr = 1000; addr_err = 0.
  - Then SW = 16'h7000 + press → addr_err = 1; mem_addr stays 1000.
- Write with verify and auto-increment:
  - Starting at mem_addr = 5, SW = 16'hA5A5, press BTN_write.
  - Expect exactly one mem_we cycle with addr 5 / data A5A5; VERIFY passes (wr_err = 0); write_count = 1; mem_addr = 6.
  - disp_value shows the rdata at 6 one cycle later.
- Wrap and mismatch:
  - mem_addr = 24575; force mem_rdata = 16'h0000 during VERIFY while writing 16'h1234.
  - Expect wr_err = 1 and mem_addr = 0. A following addr press clears wr_err.
- Debounce:
  - BTN_write toggled 1,0,1,0 at 2-cycle intervals, then held high 10 cycles.
  - Expect exactly one mem_we; no pulse on release.
- Simultaneous/busy presses:
  - Addr and write pulses in the same cycle → address latched, no mem_we.
  - Addr press arriving during VERIFY → ignored; mem_addr follows INC only.
